rv32i_program_encoder: RTL and testbench
========================================

Name: rv32i_program_encoder

Overview:
Streaming RV32I instruction encoder: the hardware inverse of the core's instruction decoder. It accepts one symbolic instruction or label command per handshake, packs it into a 32-bit RV32I word, and writes the word into program RAM through a one-word-per-cycle write port. Branch and JAL targets may name labels. Backward references resolve immediately. Forward references are queued and back-patched on END. It lets bench and boot logic build core programs in hardware.

Parameters:
ADDR_W, 8, program RAM word-address width (RAM holds 2**ADDR_W words).
NLABELS, 16, label table entries; label id width is log2(NLABELS).
NFIXUPS, 8, forward-reference fixup queue depth.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  4  0 ALUREG, 1 ALUIMM, 2 BRANCH, 3 JAL, 4 JALR, 5 LUI, 6 AUIPC, 7 LOAD, 8 STORE, 9 SYSTEM, 10 LABEL, 11 END; others are illegal
cmd_funct3  in  3  funct3 field
cmd_alt  in  1  funct7[5] (SUB/SRA/SRAI)
cmd_rd, cmd_rs1, cmd_rs2  in  5 each  register ids
cmd_imm  in  32  immediate or byte offset
cmd_use_label  in  1  BRANCH/JAL: take target from label, not from cmd_imm
cmd_label  in  log2(NLABELS)  label id
mem_wen  out  1  RAM write strobe
mem_waddr  out  ADDR_W  RAM word address
mem_wdata  out  32  encoded word
pc  out  32  byte address of the next instruction
done  out  1  program complete and patched
error  out  1  sticky error
err_code  out  3  1 label redefined, 2 fixup overflow, 3 undefined label, 4 offset out of range, 5 RAM overflow, 6 illegal op

Behaviour:
- Reset: all outputs 0, except cmd_ready, which is 1 in ACCEPT. PC=0. Label table and fixup queue are cleared. State goes to ACCEPT. Reset has priority in every state, including mid-FIXUP. No further writes issue after reset.
- States: ACCEPT -> (END) FIXUP -> DONE. Any error moves to ERROR. DONE and ERROR hold until reset. cmd_ready=1 only in ACCEPT.
- Instruction ops: the encoded word is registered. mem_wen pulses for exactly one cycle, the cycle after acceptance, with mem_waddr=PC[ADDR_W+1:2]. PC then advances by 4. Back-to-back acceptance is allowed, one instruction per cycle.
- Encodings:
  - ALUREG = {alt?0100000:0, rs2, rs1, f3, rd, 0110011}.
  - ALUIMM = {imm[11:0], rs1, f3, rd, 0010011}. When f3 is 001 or 101, bits 31:25 = alt?0100000:0 and bits 24:20 = imm[4:0].
  - BRANCH = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
  - JAL = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - JALR = I-type with f3=000, opcode 1100111.
  - LUI/AUIPC = {imm[31:12], rd, 0110111/0010111}.
  - LOAD = I-type, opcode 0000011.
  - STORE = {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - SYSTEM = {imm[11:0], 13'b0, 1110011}.
- LABEL: no write and PC unchanged. Stores label address = PC and sets the defined bit. Redefinition -> ERROR(1).
- Labelled BRANCH/JAL, label defined: offset = label_addr - PC, used as imm.
- Labelled BRANCH/JAL, label undefined: writes the word with offset 0. Pushes {word addr, label id, is_jal, zero-offset word} into the fixup queue. Pushing into a full queue -> ERROR(2) and no write issues.
- Range check: BRANCH offset must be in [-4096, 4094] and JAL offset in [-2^20, 2^20-2], else ERROR(4). The check applies to immediate, resolved and fixup offsets.
- Accepting an instruction when PC == 4*2^ADDR_W -> ERROR(5). LABEL at that PC is legal.
- Illegal cmd_op -> ERROR(6).
- FIXUP: entries are processed in queue order, one per cycle. Each entry produces one mem_wen write of the stored word OR'ed with the encoded offset (label_addr - entry_addr). An undefined label -> ERROR(3), and no write issues for that entry or any later one. After the last entry, done=1. An empty queue reaches done the cycle after END is accepted.
- ERROR: error and err_code are latched. The first error wins.

Test Plan:
- ADD x1,x0,x0; ADDI x2,x0,32; LABEL 0; ADDI x1,x1,1; BNE x1,x2,label0; SYSTEM imm=1; END -> writes addr0=0x000000B3, 1=0x02000113, 2=0x00108093, 3=0xFE209EE3, 4=0x00100073; done=1, pc=20.
- JAL x0,label1; ADDI x0,x0,0; LABEL 1; END -> addr0=0x0000006F then addr1=0x00000013, then fixup write addr0=0x0080006F; done.
- LABEL 2 issued twice -> error=1, err_code=1, cmd_ready=0, no further writes.
- NFIXUPS+1 forward BNE references -> the 9th is rejected with err_code=2; exactly 8 writes issued.
- BEQ to label 5, which is never defined, then END -> initial write only, then err_code=3 and no patch write.
- BEQ with imm=4096 -> err_code=4. Reset asserted during FIXUP -> mem_wen=0 next cycle, pc=0, cmd_ready=1.

Source files
------------

// File: rtl/rv32i_program_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_program_encoder_if
// Brief    : Command, RAM write and status bundle for the RV32I program
//            encoder. The master drives commands, the slave is the encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface rv32i_program_encoder_if #(
  parameter int ADDR_W  = 8,
  parameter int NLABELS = 16
);
  localparam int LBL_W = (NLABELS > 1) ? $clog2(NLABELS) : 1;

  // command handshake
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [2:0]        cmd_funct3;
  logic              cmd_alt;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [31:0]       cmd_imm;
  logic              cmd_use_label;
  logic [LBL_W-1:0]  cmd_label;

  // program RAM write port
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  // status
  logic [31:0]       pc;
  logic              done;
  logic              error;
  logic [2:0]        err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_funct3, cmd_alt, cmd_rd, cmd_rs1, cmd_rs2,
           cmd_imm, cmd_use_label, cmd_label,
    input  cmd_ready, mem_wen, mem_waddr, mem_wdata, pc, done, error, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_funct3, cmd_alt, cmd_rd, cmd_rs1, cmd_rs2,
           cmd_imm, cmd_use_label, cmd_label,
    output cmd_ready, mem_wen, mem_waddr, mem_wdata, pc, done, error, err_code
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_program_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_program_encoder
// Brief    : Streaming RV32I assembler. Packs symbolic commands into 32-bit
//            instruction words, writes them to program RAM one per cycle,
//            resolves backward label references at once and back-patches
//            forward references after END.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_program_encoder #(
  parameter int ADDR_W  = 8,
  parameter int NLABELS = 16,
  parameter int NFIXUPS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  rv32i_program_encoder_if.slave bus
);
  localparam int LBL_W = (NLABELS > 1) ? $clog2(NLABELS) : 1;
  localparam int FXC_W = $clog2(NFIXUPS + 1);
  localparam int FXI_W = (NFIXUPS > 1) ? $clog2(NFIXUPS) : 1;

  // one past the last RAM word, as a byte address
  localparam logic [31:0] c_PC_LIMIT = 32'd4 << ADDR_W;

  localparam logic [1:0] c_ST_ACCEPT = 2'd0;
  localparam logic [1:0] c_ST_FIXUP  = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;
  localparam logic [1:0] c_ST_ERROR  = 2'd3;

  localparam logic [3:0] c_OP_ALUREG = 4'd0;
  localparam logic [3:0] c_OP_ALUIMM = 4'd1;
  localparam logic [3:0] c_OP_BRANCH = 4'd2;
  localparam logic [3:0] c_OP_JAL    = 4'd3;
  localparam logic [3:0] c_OP_JALR   = 4'd4;
  localparam logic [3:0] c_OP_LUI    = 4'd5;
  localparam logic [3:0] c_OP_AUIPC  = 4'd6;
  localparam logic [3:0] c_OP_LOAD   = 4'd7;
  localparam logic [3:0] c_OP_STORE  = 4'd8;
  localparam logic [3:0] c_OP_SYSTEM = 4'd9;
  localparam logic [3:0] c_OP_LABEL  = 4'd10;
  localparam logic [3:0] c_OP_END    = 4'd11;

  localparam logic [2:0] c_ERR_NONE    = 3'd0;
  localparam logic [2:0] c_ERR_REDEF   = 3'd1;
  localparam logic [2:0] c_ERR_FXFULL  = 3'd2;
  localparam logic [2:0] c_ERR_UNDEF   = 3'd3;
  localparam logic [2:0] c_ERR_RANGE   = 3'd4;
  localparam logic [2:0] c_ERR_RAMFULL = 3'd5;
  localparam logic [2:0] c_ERR_ILLEGAL = 3'd6;

  // B-type immediate scattered into its instruction bit positions
  function automatic logic [31:0] f_b_imm(input logic [12:1] o);
    return {o[12], o[10:5], 13'b0, o[4:1], o[11], 7'b0};
  endfunction

  // J-type immediate scattered into its instruction bit positions
  function automatic logic [31:0] f_j_imm(input logic [20:1] o);
    return {o[20], o[10:1], o[11], o[19:12], 12'b0};
  endfunction

  function automatic logic f_br_ok(input logic [31:0] o);
    return ($signed(o) >= -32'sd4096) && ($signed(o) <= 32'sd4094);
  endfunction

  function automatic logic f_jal_ok(input logic [31:0] o);
    return ($signed(o) >= -32'sd1048576) && ($signed(o) <= 32'sd1048574);
  endfunction

  // control and status
  logic [1:0]        r_state;
  logic [31:0]       r_pc;
  logic              r_mem_wen;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [31:0]       r_mem_wdata;
  logic              r_done;
  logic              r_error;
  logic [2:0]        r_err_code;

  // label table
  logic [NLABELS-1:0] r_lbl_def;
  logic [31:0]        r_lbl_addr [0:NLABELS-1];

  // fixup queue: filled only while accepting, drained only in FIXUP,
  // so a push index (count) and a pop index (head) are all that is needed
  logic [FXC_W-1:0]  r_fx_cnt;
  logic [FXC_W-1:0]  r_fx_head;
  logic [ADDR_W-1:0] r_fx_addr [0:NFIXUPS-1];
  logic [LBL_W-1:0]  r_fx_lbl  [0:NFIXUPS-1];
  logic              r_fx_jal  [0:NFIXUPS-1];
  logic [31:0]       r_fx_word [0:NFIXUPS-1];

  // accept-path decode
  logic        w_lbl_def;
  logic [31:0] w_lbl_addr;
  logic        w_by_label;
  logic        w_forward;
  logic [31:0] w_off;
  logic        w_range_ok;
  logic [31:0] w_word;
  logic [2:0]  w_acc_err;
  logic        w_fx_full;
  logic        w_accept;
  logic        w_is_insn;

  // fixup-path decode
  logic [FXI_W-1:0]  w_fx_idx;
  logic [FXC_W-1:0]  w_fx_next;
  logic [LBL_W-1:0]  w_fx_lbl;
  logic              w_fx_def;
  logic [31:0]       w_fx_off;
  logic              w_fx_ok;
  logic [31:0]       w_fx_word;

  assign w_accept  = bus.cmd_valid && (r_state == c_ST_ACCEPT);
  assign w_fx_full = (r_fx_cnt == FXC_W'(NFIXUPS));
  assign w_is_insn = (bus.cmd_op != c_OP_LABEL) && (bus.cmd_op != c_OP_END);

  // resolve the immediate, encode the word and classify any error for the
  // command currently presented
  always_comb begin
    w_lbl_def  = r_lbl_def[bus.cmd_label];
    w_lbl_addr = r_lbl_addr[bus.cmd_label];
    w_by_label = ((bus.cmd_op == c_OP_BRANCH) || (bus.cmd_op == c_OP_JAL)) &&
                 bus.cmd_use_label;
    w_forward  = w_by_label && !w_lbl_def;
    w_off      = bus.cmd_imm;
    if (w_by_label) begin
      w_off = w_lbl_def ? (w_lbl_addr - r_pc) : 32'd0;
    end

    w_range_ok = 1'b1;
    if (bus.cmd_op == c_OP_BRANCH) begin
      w_range_ok = f_br_ok(w_off);
    end else if (bus.cmd_op == c_OP_JAL) begin
      w_range_ok = f_jal_ok(w_off);
    end

    w_word = 32'd0;
    case (bus.cmd_op)
      c_OP_ALUREG: w_word = {(bus.cmd_alt ? 7'b0100000 : 7'b0000000), bus.cmd_rs2,
                             bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, 7'b0110011};
      c_OP_ALUIMM: begin
        if ((bus.cmd_funct3 == 3'b001) || (bus.cmd_funct3 == 3'b101)) begin
          w_word = {(bus.cmd_alt ? 7'b0100000 : 7'b0000000), bus.cmd_imm[4:0],
                    bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd, 7'b0010011};
        end else begin
          w_word = {bus.cmd_imm[11:0], bus.cmd_rs1, bus.cmd_funct3, bus.cmd_rd,
                    7'b0010011};
        end
      end
      c_OP_BRANCH: w_word = f_b_imm(w_off[12:1]) |
                            {7'b0, bus.cmd_rs2, bus.cmd_rs1, bus.cmd_funct3,
                             5'b0, 7'b1100011};
      c_OP_JAL:    w_word = f_j_imm(w_off[20:1]) | {20'b0, bus.cmd_rd, 7'b1101111};
      c_OP_JALR:   w_word = {bus.cmd_imm[11:0], bus.cmd_rs1, 3'b000, bus.cmd_rd,
                             7'b1100111};
      c_OP_LUI:    w_word = {bus.cmd_imm[31:12], bus.cmd_rd, 7'b0110111};
      c_OP_AUIPC:  w_word = {bus.cmd_imm[31:12], bus.cmd_rd, 7'b0010111};
      c_OP_LOAD:   w_word = {bus.cmd_imm[11:0], bus.cmd_rs1, bus.cmd_funct3,
                             bus.cmd_rd, 7'b0000011};
      c_OP_STORE:  w_word = {bus.cmd_imm[11:5], bus.cmd_rs2, bus.cmd_rs1,
                             bus.cmd_funct3, bus.cmd_imm[4:0], 7'b0100011};
      c_OP_SYSTEM: w_word = {bus.cmd_imm[11:0], 13'b0, 7'b1110011};
      default:     w_word = 32'd0;
    endcase

    // a LABEL at the end of RAM is still legal, only instructions overflow
    w_acc_err = c_ERR_NONE;
    if (bus.cmd_op > c_OP_END) begin
      w_acc_err = c_ERR_ILLEGAL;
    end else if (bus.cmd_op == c_OP_LABEL) begin
      if (w_lbl_def) w_acc_err = c_ERR_REDEF;
    end else if (bus.cmd_op != c_OP_END) begin
      if (r_pc == c_PC_LIMIT)         w_acc_err = c_ERR_RAMFULL;
      else if (!w_range_ok)           w_acc_err = c_ERR_RANGE;
      else if (w_forward && w_fx_full) w_acc_err = c_ERR_FXFULL;
    end
  end

  // patch offset for the queue entry at the head
  always_comb begin
    w_fx_idx  = r_fx_head[FXI_W-1:0];
    w_fx_next = r_fx_head + 1'b1;
    w_fx_lbl  = r_fx_lbl[w_fx_idx];
    w_fx_def  = r_lbl_def[w_fx_lbl];
    w_fx_off  = r_lbl_addr[w_fx_lbl] -
                {{(30-ADDR_W){1'b0}}, r_fx_addr[w_fx_idx], 2'b00};
    w_fx_ok   = r_fx_jal[w_fx_idx] ? f_jal_ok(w_fx_off) : f_br_ok(w_fx_off);
    w_fx_word = r_fx_word[w_fx_idx] |
                (r_fx_jal[w_fx_idx] ? f_j_imm(w_fx_off[20:1]) : f_b_imm(w_fx_off[12:1]));
  end

  // label addresses and fixup entries; validity is tracked by r_lbl_def and
  // r_fx_cnt, so the storage itself needs no reset
  always_ff @(posedge clock) begin
    if (!reset && w_accept && (w_acc_err == c_ERR_NONE)) begin
      if (bus.cmd_op == c_OP_LABEL) begin
        r_lbl_addr[bus.cmd_label] <= r_pc;
      end else if (w_is_insn && w_forward) begin
        r_fx_addr[r_fx_cnt[FXI_W-1:0]] <= r_pc[ADDR_W+1:2];
        r_fx_lbl[r_fx_cnt[FXI_W-1:0]]  <= bus.cmd_label;
        r_fx_jal[r_fx_cnt[FXI_W-1:0]]  <= (bus.cmd_op == c_OP_JAL);
        r_fx_word[r_fx_cnt[FXI_W-1:0]] <= w_word;
      end
    end
  end

  // control FSM, RAM write port and sticky status
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_ST_ACCEPT;
      r_pc        <= 32'd0;
      r_mem_wen   <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= 32'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= c_ERR_NONE;
      r_lbl_def   <= '0;
      r_fx_cnt    <= '0;
      r_fx_head   <= '0;
    end else begin
      r_mem_wen <= 1'b0;
      case (r_state)
        c_ST_ACCEPT: begin
          if (bus.cmd_valid) begin
            if (w_acc_err != c_ERR_NONE) begin
              r_state    <= c_ST_ERROR;
              r_error    <= 1'b1;
              r_err_code <= w_acc_err;
            end else if (bus.cmd_op == c_OP_LABEL) begin
              r_lbl_def[bus.cmd_label] <= 1'b1;
            end else if (bus.cmd_op == c_OP_END) begin
              if (r_fx_cnt == '0) begin
                r_state <= c_ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= c_ST_FIXUP;
              end
            end else begin
              r_mem_wen   <= 1'b1;
              r_mem_waddr <= r_pc[ADDR_W+1:2];
              r_mem_wdata <= w_word;
              r_pc        <= r_pc + 32'd4;
              if (w_forward) r_fx_cnt <= r_fx_cnt + 1'b1;
            end
          end
        end
        c_ST_FIXUP: begin
          if (!w_fx_def) begin
            r_state    <= c_ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= c_ERR_UNDEF;
          end else if (!w_fx_ok) begin
            r_state    <= c_ST_ERROR;
            r_error    <= 1'b1;
            r_err_code <= c_ERR_RANGE;
          end else begin
            r_mem_wen   <= 1'b1;
            r_mem_waddr <= r_fx_addr[w_fx_idx];
            r_mem_wdata <= w_fx_word;
            r_fx_head   <= w_fx_next;
            if (w_fx_next == r_fx_cnt) begin
              r_state <= c_ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          // DONE and ERROR hold until reset
          r_state <= r_state;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == c_ST_ACCEPT);
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_waddr = r_mem_waddr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.pc        = r_pc;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_program_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_program_encoder
// Brief    : Directed self-checking bench for rv32i_program_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_program_encoder;
  localparam logic [3:0] c_ALUREG = 4'd0;
  localparam logic [3:0] c_ALUIMM = 4'd1;
  localparam logic [3:0] c_BRANCH = 4'd2;
  localparam logic [3:0] c_JAL    = 4'd3;
  localparam logic [3:0] c_SYSTEM = 4'd9;
  localparam logic [3:0] c_LABEL  = 4'd10;
  localparam logic [3:0] c_END    = 4'd11;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // write log filled by the monitor only
  logic [7:0]  wa [0:1023];
  logic [31:0] wd [0:1023];
  int          wn = 0;
  int          base;

  rv32i_program_encoder_if #(.ADDR_W(8), .NLABELS(16)) bus ();

  rv32i_program_encoder #(.ADDR_W(8), .NLABELS(16), .NFIXUPS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // log every RAM write, sampled mid-cycle
  always @(negedge clock) begin
    if (bus.mem_wen === 1'b1 && wn < 1024) begin
      wa[wn] <= bus.mem_waddr;
      wd[wn] <= bus.mem_wdata;
      wn     <= wn + 1;
    end
  end

  task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic use_lbl, input logic [3:0] lbl);
    bus.cmd_valid     = 1'b1;
    bus.cmd_op        = op;
    bus.cmd_funct3    = f3;
    bus.cmd_alt       = 1'b0;
    bus.cmd_rd        = rd;
    bus.cmd_rs1       = rs1;
    bus.cmd_rs2       = rs2;
    bus.cmd_imm       = imm;
    bus.cmd_use_label = use_lbl;
    bus.cmd_label     = lbl;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    base = wn;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 4'd0; bus.cmd_funct3 = 3'd0; bus.cmd_alt = 1'b0;
    bus.cmd_rd = 5'd0; bus.cmd_rs1 = 5'd0; bus.cmd_rs2 = 5'd0;
    bus.cmd_imm = 32'd0; bus.cmd_use_label = 1'b0; bus.cmd_label = 4'd0;
    do_reset();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.mem_wen !== 1'b0 || bus.pc !== 32'd0 ||
        bus.done !== 1'b0 || bus.error !== 1'b0 || bus.err_code !== 3'd0 ||
        bus.mem_waddr !== 8'd0 || bus.mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got ready=%b wen=%b pc=%h done=%b err=%b code=%0d waddr=%h wdata=%h exp ready=1 rest=0",
               bus.cmd_ready, bus.mem_wen, bus.pc, bus.done, bus.error, bus.err_code,
               bus.mem_waddr, bus.mem_wdata);
    end
  endtask

  task automatic test_loop_program();
    logic [31:0] exp_d [0:4];
    exp_d[0] = 32'h000000B3; exp_d[1] = 32'h02000113; exp_d[2] = 32'h00108093;
    exp_d[3] = 32'hFE209EE3; exp_d[4] = 32'h00100073;
    do_reset();
    send(c_ALUREG, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    send(c_ALUIMM, 3'd0, 5'd2, 5'd0, 5'd0, 32'd32, 1'b0, 4'd0);
    send(c_LABEL,  3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    send(c_ALUIMM, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0, 4'd0);
    send(c_BRANCH, 3'd1, 5'd0, 5'd1, 5'd2, 32'd0, 1'b1, 4'd0);
    send(c_SYSTEM, 3'd0, 5'd0, 5'd0, 5'd0, 32'd1, 1'b0, 4'd0);
    send(c_END,    3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clock);
    idle(1);
    checks++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.pc !== 32'd20) begin
      failures++;
      $display("FAIL loop_done got done=%b err=%b pc=%0d exp done=1 err=0 pc=20",
               bus.done, bus.error, bus.pc);
    end
    checks++;
    if (wn - base !== 5) begin
      failures++;
      $display("FAIL loop_write_count got=%0d exp=5", wn - base);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wa[base+i] !== 8'(i) || wd[base+i] !== exp_d[i]) begin
        failures++;
        $display("FAIL loop_write%0d got addr=%0d data=%h exp addr=%0d data=%h",
                 i, wa[base+i], wd[base+i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_forward_jal();
    do_reset();
    send(c_JAL,    3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 4'd1);
    send(c_ALUIMM, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    send(c_LABEL,  3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd1);
    send(c_END,    3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && bus.done !== 1'b1; i++) @(negedge clock);
    idle(2);
    checks++;
    if (bus.done !== 1'b1 || wn - base !== 3) begin
      failures++;
      $display("FAIL fwd_done got done=%b writes=%0d exp done=1 writes=3", bus.done, wn - base);
    end
    checks++;
    if (wa[base] !== 8'd0 || wd[base] !== 32'h0000006F ||
        wa[base+1] !== 8'd1 || wd[base+1] !== 32'h00000013) begin
      failures++;
      $display("FAIL fwd_initial got %0d:%h %0d:%h exp 0:0000006f 1:00000013",
               wa[base], wd[base], wa[base+1], wd[base+1]);
    end
    checks++;
    if (wa[base+2] !== 8'd0 || wd[base+2] !== 32'h0080006F) begin
      failures++;
      $display("FAIL fwd_patch got addr=%0d data=%h exp addr=0 data=0080006f",
               wa[base+2], wd[base+2]);
    end
  endtask

  task automatic test_label_redefine();
    do_reset();
    send(c_LABEL,  3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd2);
    send(c_LABEL,  3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd2);
    send(c_ALUIMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 4'd0);
    send(c_ALUIMM, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 4'd0);
    idle(2);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 3'd1 || bus.cmd_ready !== 1'b0 ||
        wn - base !== 0) begin
      failures++;
      $display("FAIL label_redef got err=%b code=%0d ready=%b writes=%0d exp err=1 code=1 ready=0 writes=0",
               bus.error, bus.err_code, bus.cmd_ready, wn - base);
    end
  endtask

  task automatic test_fixup_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) send(c_BRANCH, 3'd1, 5'd0, 5'd1, 5'd2, 32'd0, 1'b1, 4'd7);
    idle(2);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 3'd2 || bus.pc !== 32'd32) begin
      failures++;
      $display("FAIL fx_overflow got err=%b code=%0d pc=%0d exp err=1 code=2 pc=32",
               bus.error, bus.err_code, bus.pc);
    end
    checks++;
    if (wn - base !== 8) begin
      failures++;
      $display("FAIL fx_overflow_writes got=%0d exp=8", wn - base);
    end
    checks++;
    if (wa[base+7] !== 8'd7 || wd[base+7] !== 32'h00209063) begin
      failures++;
      $display("FAIL fx_overflow_last got addr=%0d data=%h exp addr=7 data=00209063",
               wa[base+7], wd[base+7]);
    end
  endtask

  task automatic test_undefined_label();
    do_reset();
    send(c_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 4'd5);
    send(c_END,    3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && bus.error !== 1'b1; i++) @(negedge clock);
    idle(2);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 3'd3 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL undef_label got err=%b code=%0d done=%b exp err=1 code=3 done=0",
               bus.error, bus.err_code, bus.done);
    end
    checks++;
    if (wn - base !== 1 || wd[base] !== 32'h00000063) begin
      failures++;
      $display("FAIL undef_label_writes got n=%0d data=%h exp n=1 data=00000063",
               wn - base, wd[base]);
    end
  endtask

  task automatic test_range();
    do_reset();
    send(c_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, -32'sd4096, 1'b0, 4'd0);
    send(c_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b0, 4'd0);
    send(c_JAL,    3'd0, 5'd0, 5'd0, 5'd0, 32'd1048574, 1'b0, 4'd0);
    send(c_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4096, 1'b0, 4'd0);
    idle(2);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 3'd4 || wn - base !== 3) begin
      failures++;
      $display("FAIL br_range got err=%b code=%0d writes=%0d exp err=1 code=4 writes=3",
               bus.error, bus.err_code, wn - base);
    end
    checks++;
    if (wd[base] !== 32'h80000063 || wd[base+1] !== 32'h7E000FE3 ||
        wd[base+2] !== 32'h7FFFF06F) begin
      failures++;
      $display("FAIL range_edges got %h %h %h exp 80000063 7e000fe3 7ffff06f",
               wd[base], wd[base+1], wd[base+2]);
    end
    do_reset();
    send(c_JAL, 3'd0, 5'd0, 5'd0, 5'd0, 32'd1048576, 1'b0, 4'd0);
    idle(2);
    checks++;
    if (bus.err_code !== 3'd4 || wn - base !== 0) begin
      failures++;
      $display("FAIL jal_range got code=%0d writes=%0d exp code=4 writes=0",
               bus.err_code, wn - base);
    end
  endtask

  task automatic test_illegal_op();
    do_reset();
    send(4'd12, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    idle(2);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 3'd6 || wn - base !== 0) begin
      failures++;
      $display("FAIL illegal_op got err=%b code=%0d writes=%0d exp err=1 code=6 writes=0",
               bus.error, bus.err_code, wn - base);
    end
  endtask

  task automatic test_back_to_back_ram_full();
    do_reset();
    for (int i = 0; i < 256; i++) send(c_ALUIMM, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    send(c_LABEL, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd3);
    idle(1);
    checks++;
    if (bus.error !== 1'b0 || bus.pc !== 32'd1024 || wn - base !== 256 ||
        wa[base+255] !== 8'd255) begin
      failures++;
      $display("FAIL ram_fill got err=%b pc=%0d writes=%0d last=%0d exp err=0 pc=1024 writes=256 last=255",
               bus.error, bus.pc, wn - base, wa[base+255]);
    end
    send(c_ALUIMM, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    idle(2);
    checks++;
    if (bus.err_code !== 3'd5 || wn - base !== 256) begin
      failures++;
      $display("FAIL ram_overflow got code=%0d writes=%0d exp code=5 writes=256",
               bus.err_code, wn - base);
    end
  endtask

  task automatic test_reset_in_fixup();
    do_reset();
    for (int i = 0; i < 4; i++) send(c_BRANCH, 3'd1, 5'd0, 5'd1, 5'd2, 32'd0, 1'b1, 4'd6);
    send(c_LABEL, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd6);
    send(c_END,   3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 4'd0);
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.mem_wen !== 1'b0 || bus.pc !== 32'd0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_fixup got wen=%b pc=%0d ready=%b exp wen=0 pc=0 ready=1",
               bus.mem_wen, bus.pc, bus.cmd_ready);
    end
    checks++;
    if (wn - base !== 5 || wa[base+4] !== 8'd0 || wd[base+4] !== 32'h00209863) begin
      failures++;
      $display("FAIL first_patch got n=%0d addr=%0d data=%h exp n=5 addr=0 data=00209863",
               wn - base, wa[base+4], wd[base+4]);
    end
    reset = 1'b0;
    idle(6);
    checks++;
    if (wn - base !== 5 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_quiet got writes=%0d done=%b exp writes=5 done=0",
               wn - base, bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_loop_program();
    test_forward_jal();
    test_label_redefine();
    test_fixup_overflow();
    test_undefined_label();
    test_range();
    test_illegal_op();
    test_back_to_back_ram_full();
    test_reset_in_fixup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
